irq_controller: RTL and testbench

Interrupt controller that sits between the peripheral `irqs` outputs (timers, RTC, keypad, …) and the CPU core. It latches per-source interrupt pulses into active flags and gates them with per-source enable bits and per-group 2-bit priorities. It arbitrates a single winning source and presents its vector and priority to the CPU through a request/acknowledge handshake. Software reads, enables and write-1-clears the flags through the system bus.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_arbiter.sv | 47 ++++
 rtl/irq_controller.sv | 150 +++++++++++++++
 tb/tb_irq_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   IRQ_SRCS / IRQ_GROUPS : number of sources and priority groups
//   SRC_GROUP             : fixed source -> priority group table
//   irq_state_t           : CPU handshake FSM states
package irq_pkg;

  localparam int IRQ_SRCS   = 32;
  localparam int IRQ_GROUPS = 12;

  // Source n belongs to group (n mod 12).
  localparam logic [3:0] SRC_GROUP [0:IRQ_SRCS-1] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
    4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7
  };

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_HOLD = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_arbiter.sv
// Combinational interrupt arbiter.
//   act, ena   : per-source active flags and enable bits
//   pri        : 12 groups x 2-bit priority
//   cpu_level  : current CPU mask level
//   valid      : a candidate exists
//   index      : winning source (highest priority, lowest index on tie)
//   prio       : priority of the winning source
module irq_arbiter
  import irq_pkg::*;
(
  input  logic [IRQ_SRCS-1:0]     act,
  input  logic [IRQ_SRCS-1:0]     ena,
  input  logic [2*IRQ_GROUPS-1:0] pri,
  input  logic [1:0]              cpu_level,
  output logic                    valid,
  output logic [4:0]              index,
  output logic [1:0]              prio
);

  logic [1:0]          src_prio [IRQ_SRCS];
  logic [IRQ_SRCS-1:0] cand;

  generate
    for (genvar gi = 0; gi < IRQ_SRCS; gi++) begin : g_src
      localparam int GRP = int'(SRC_GROUP[gi]);
      assign src_prio[gi] = pri[2*GRP +: 2];
      // Priority 0 means "never interrupt", independent of cpu_level.
      assign cand[gi] = act[gi] & ena[gi] & (src_prio[gi] != 2'd0) &
                        (src_prio[gi] > cpu_level);
    end
  endgenerate

  // Ascending scan with strict '>' keeps the lowest index on ties.
  always_comb begin
    valid = 1'b0;
    index = 5'd0;
    prio  = 2'd0;
    for (int n = 0; n < IRQ_SRCS; n++) begin
      if (cand[n] && (!valid || (src_prio[n] > prio))) begin
        valid = 1'b1;
        index = 5'(n);
        prio  = src_prio[n];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches source pulses into active flags, exposes
// flag/enable/priority registers on the system bus and drives a
// request/acknowledge handshake towards the CPU.
//   clk, reset          : clock, synchronous active-high reset
//   clk_ce_cpu          : CPU clock enable (bus writes, FSM)
//   bus_*               : system bus; reads are combinational
//   irq_in              : per-source pulses, sampled every clk
//   cpu_level, irq_ack  : CPU mask level and acknowledge
//   irq_req/vector/priority : request and latched winner
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [23:0] IRQ_PRI = 24'h2020,
  parameter logic [23:0] IRQ_ENA = 24'h2023,
  parameter logic [23:0] IRQ_ACT = 24'h2027
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_ce_cpu,
  input  logic                bus_write,
  input  logic                bus_read,
  input  logic [23:0]         bus_address_in,
  input  logic [7:0]          bus_data_in,
  output logic [7:0]          bus_data_out,
  input  logic [IRQ_SRCS-1:0] irq_in,
  input  logic [1:0]          cpu_level,
  input  logic                irq_ack,
  output logic                irq_req,
  output logic [4:0]          irq_vector,
  output logic [1:0]          irq_priority
);

  logic [IRQ_SRCS-1:0]     act_reg;
  logic [IRQ_SRCS-1:0]     ena_reg;
  logic [2*IRQ_GROUPS-1:0] pri_reg;
  logic [IRQ_SRCS-1:0]     clear_mask;
  irq_state_t              state_reg;
  logic [4:0]              vector_reg;
  logic [1:0]              priority_reg;

  logic [3:0] act_hit;
  logic [3:0] ena_hit;
  logic [2:0] pri_hit;
  logic       wr_en;

  logic       win_valid;
  logic [4:0] win_index;
  logic [1:0] win_prio;

  // Reads are combinational, so the strobe carries no information here.
  logic unused_bus_read;
  assign unused_bus_read = bus_read;

  assign wr_en = clk_ce_cpu & bus_write;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word_dec
      assign act_hit[gi] = (bus_address_in == IRQ_ACT + 24'(gi));
      assign ena_hit[gi] = (bus_address_in == IRQ_ENA + 24'(gi));
      assign clear_mask[8*gi +: 8] = (wr_en && act_hit[gi]) ? bus_data_in : 8'h00;
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_pri_dec
      assign pri_hit[gi] = (bus_address_in == IRQ_PRI + 24'(gi));
    end
  endgenerate

  // Flags latch every clk; OR-ing irq_in last makes a new pulse win over
  // a simultaneous write-1-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_reg <= '0;
    end else begin
      act_reg <= (act_reg & ~clear_mask) | irq_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ena_reg <= '0;
      pri_reg <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (ena_hit[k]) ena_reg[8*k +: 8] <= bus_data_in;
      end
      for (int k = 0; k < 3; k++) begin
        if (pri_hit[k]) pri_reg[8*k +: 8] <= bus_data_in;
      end
    end
  end

  always_comb begin
    bus_data_out = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (act_hit[k]) bus_data_out = act_reg[8*k +: 8];
      if (ena_hit[k]) bus_data_out = ena_reg[8*k +: 8];
    end
    for (int k = 0; k < 3; k++) begin
      if (pri_hit[k]) bus_data_out = pri_reg[8*k +: 8];
    end
  end

  irq_arbiter u_arbiter (
    .act       (act_reg),
    .ena       (ena_reg),
    .pri       (pri_reg),
    .cpu_level (cpu_level),
    .valid     (win_valid),
    .index     (win_index),
    .prio      (win_prio)
  );

  // The arbiter sees the registers as they were before this cycle's write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IRQ_IDLE;
      vector_reg   <= 5'd0;
      priority_reg <= 2'd0;
    end else if (clk_ce_cpu) begin
      case (state_reg)
        IRQ_IDLE: begin
          if (win_valid) begin
            vector_reg   <= win_index;
            priority_reg <= win_prio;
            state_reg    <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            state_reg <= IRQ_HOLD;
          end else if (!win_valid) begin
            state_reg <= IRQ_IDLE;
          end else begin
            // Re-latch so a higher-priority source can preempt before ack.
            vector_reg   <= win_index;
            priority_reg <= win_prio;
          end
        end
        IRQ_HOLD: begin
          if (!irq_ack) state_reg <= IRQ_IDLE;
        end
        default: state_reg <= IRQ_IDLE;
      endcase
    end
  end

  assign irq_req      = (state_reg == IRQ_REQ);
  assign irq_vector   = vector_reg;
  assign irq_priority = priority_reg;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_ce_cpu;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [31:0] irq_in;
  logic [1:0]  cpu_level;
  logic        irq_ack;
  logic        irq_req;
  logic [4:0]  irq_vector;
  logic [1:0]  irq_priority;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .clk            (clk),
    .reset          (reset),
    .clk_ce_cpu     (clk_ce_cpu),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irq_in         (irq_in),
    .cpu_level      (cpu_level),
    .irq_ack        (irq_ack),
    .irq_req        (irq_req),
    .irq_vector     (irq_vector),
    .irq_priority   (irq_priority)
  );

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
    logic [31:0] irq;
    logic [1:0]  lvl;
    logic        ack;
    logic        exp_req;
    logic [4:0]  exp_vec;
    logic [1:0]  exp_pri;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NVEC = 32;
  vec_t vecs [0:NVEC-1];

  function automatic vec_t mk(input logic wr, input logic [23:0] addr,
                              input logic [7:0] data, input logic [31:0] irq,
                              input logic [1:0] lvl, input logic ack,
                              input logic req, input logic [4:0] vec,
                              input logic [1:0] pri, input logic [7:0] rd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.irq = irq; v.lvl = lvl;
    v.ack = ack; v.exp_req = req; v.exp_vec = vec; v.exp_pri = pri; v.exp_rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act_v,
                       input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic req,
                           input logic [4:0] vec, input logic [1:0] pri);
    check({tag, ".req"}, 32'(irq_req), 32'(req));
    check({tag, ".vec"}, 32'(irq_vector), 32'(vec));
    check({tag, ".pri"}, 32'(irq_priority), 32'(pri));
  endtask

  initial begin
    // Directed table, clk_ce_cpu constantly high. Each row is one clk;
    // outputs and bus_data_out (at row address) are checked after the edge.
    vecs[0]  = mk(1, 24'h2023, 8'h04, 32'h0,   0, 0, 0, 0, 0, 8'h04);
    vecs[1]  = mk(1, 24'h2020, 8'h20, 32'h0,   0, 0, 0, 0, 0, 8'h20);
    vecs[2]  = mk(0, 24'h2027, 8'h00, 32'h4,   0, 0, 0, 0, 0, 8'h04);
    vecs[3]  = mk(0, 24'h2027, 8'h00, 32'h0,   0, 0, 1, 2, 2, 8'h04);
    vecs[4]  = mk(0, 24'h2027, 8'h00, 32'h0,   0, 1, 0, 2, 2, 8'h04);
    vecs[5]  = mk(0, 24'h2027, 8'h00, 32'h0,   0, 1, 0, 2, 2, 8'h04);
    vecs[6]  = mk(0, 24'h2027, 8'h00, 32'h0,   0, 0, 0, 2, 2, 8'h04);
    vecs[7]  = mk(0, 24'h2027, 8'h00, 32'h0,   0, 0, 1, 2, 2, 8'h04);
    vecs[8]  = mk(1, 24'h2027, 8'h04, 32'h0,   0, 0, 1, 2, 2, 8'h00);
    vecs[9]  = mk(0, 24'h2027, 8'h00, 32'h0,   0, 0, 0, 2, 2, 8'h00);
    vecs[10] = mk(0, 24'h2027, 8'h00, 32'h0,   0, 0, 0, 2, 2, 8'h00);
    vecs[11] = mk(0, 24'h2027, 8'h00, 32'h4,   2, 0, 0, 2, 2, 8'h04);
    vecs[12] = mk(0, 24'h2027, 8'h00, 32'h0,   2, 0, 0, 2, 2, 8'h04);
    vecs[13] = mk(0, 24'h2027, 8'h00, 32'h0,   2, 0, 0, 2, 2, 8'h04);
    vecs[14] = mk(0, 24'h2027, 8'h00, 32'h0,   1, 0, 1, 2, 2, 8'h04);
    vecs[15] = mk(1, 24'h2027, 8'h04, 32'h0,   1, 0, 1, 2, 2, 8'h00);
    vecs[16] = mk(0, 24'h2027, 8'h00, 32'h0,   0, 0, 0, 2, 2, 8'h00);
    vecs[17] = mk(1, 24'h2023, 8'h08, 32'h0,   0, 0, 0, 2, 2, 8'h08);
    vecs[18] = mk(1, 24'h2024, 8'h02, 32'h0,   0, 0, 0, 2, 2, 8'h02);
    vecs[19] = mk(1, 24'h2020, 8'h40, 32'h0,   0, 0, 0, 2, 2, 8'h40);
    vecs[20] = mk(1, 24'h2022, 8'h0C, 32'h0,   0, 0, 0, 2, 2, 8'h0C);
    vecs[21] = mk(0, 24'h2027, 8'h00, 32'h208, 0, 0, 0, 2, 2, 8'h08);
    vecs[22] = mk(0, 24'h2028, 8'h00, 32'h0,   0, 0, 1, 9, 3, 8'h02);
    vecs[23] = mk(1, 24'h2020, 8'hC0, 32'h0,   0, 0, 1, 9, 3, 8'hC0);
    vecs[24] = mk(0, 24'h2020, 8'h00, 32'h0,   0, 0, 1, 3, 3, 8'hC0);
    vecs[25] = mk(1, 24'h2027, 8'h20, 32'h20,  0, 0, 1, 3, 3, 8'h28);
    vecs[26] = mk(1, 24'h2027, 8'h08, 32'h0,   0, 0, 1, 3, 3, 8'h20);
    vecs[27] = mk(1, 24'h2028, 8'h02, 32'h0,   0, 0, 1, 9, 3, 8'h00);
    vecs[28] = mk(0, 24'h2027, 8'h00, 32'h0,   0, 0, 0, 9, 3, 8'h20);
    vecs[29] = mk(0, 24'h202B, 8'h00, 32'h0,   0, 0, 0, 9, 3, 8'h00);
    vecs[30] = mk(0, 24'h201F, 8'h00, 32'h0,   0, 0, 0, 9, 3, 8'h00);
    vecs[31] = mk(0, 24'h2026, 8'h00, 32'h0,   0, 0, 0, 9, 3, 8'h00);

    reset = 1'b1; clk_ce_cpu = 1'b1; bus_write = 1'b0; bus_read = 1'b0;
    bus_address_in = 24'h0; bus_data_in = 8'h0; irq_in = 32'h0;
    cpu_level = 2'd0; irq_ack = 1'b0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_out("reset", 0, 0, 0);
    bus_address_in = 24'h2027; #1; check("reset.act0", 32'(bus_data_out), 0);
    bus_address_in = 24'h2023; #1; check("reset.ena0", 32'(bus_data_out), 0);
    bus_address_in = 24'h2020; #1; check("reset.pri0", 32'(bus_data_out), 0);

    for (int i = 0; i < NVEC; i++) begin
      bus_write      = vecs[i].wr;
      bus_read       = ~vecs[i].wr;
      bus_address_in = vecs[i].addr;
      bus_data_in    = vecs[i].data;
      irq_in         = vecs[i].irq;
      cpu_level      = vecs[i].lvl;
      irq_ack        = vecs[i].ack;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_vec,
                vecs[i].exp_pri);
      check($sformatf("vec%0d.rd", i), 32'(bus_data_out), 32'(vecs[i].exp_rd));
      $display("vec %0d: addr=%06h req=%0b vector=%0d prio=%0d rd=%02h",
               i, vecs[i].addr, irq_req, irq_vector, irq_priority, bus_data_out);
    end

    // Gated clk_ce_cpu sequence (enable 1 cycle in 4), from a fresh reset.
    bus_write = 1'b0; irq_in = 32'h0; cpu_level = 2'd0; irq_ack = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;

    // Writes without clk_ce_cpu are ignored.
    clk_ce_cpu = 1'b0; bus_write = 1'b1;
    bus_address_in = 24'h2023; bus_data_in = 8'h04;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("gate.ena_hold%0d", c), 32'(bus_data_out), 0);
    end
    clk_ce_cpu = 1'b1; step();
    check("gate.ena_write", 32'(bus_data_out), 32'h04);
    bus_address_in = 24'h2020; bus_data_in = 8'h20; step();
    check("gate.pri_write", 32'(bus_data_out), 32'h20);
    bus_write = 1'b0;
    $display("gate: configured ena=04 pri=20");

    // Flag latches on a disabled cycle; FSM waits for the enable.
    clk_ce_cpu = 1'b0; bus_address_in = 24'h2027; irq_in = 32'h4; step();
    irq_in = 32'h0;
    check("gate.act_latch", 32'(bus_data_out), 32'h04);
    check("gate.req_wait0", 32'(irq_req), 0);
    step(); check("gate.req_wait1", 32'(irq_req), 0);
    step(); check("gate.req_wait2", 32'(irq_req), 0);
    clk_ce_cpu = 1'b1; step();
    check_out("gate.req", 1, 2, 2);
    $display("gate: request raised req=%0b vector=%0d", irq_req, irq_vector);

    // Ack only counts on enabled cycles.
    clk_ce_cpu = 1'b0; irq_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("gate.ack_wait%0d", c), 32'(irq_req), 1);
    end
    clk_ce_cpu = 1'b1; step();
    check_out("gate.ack", 0, 2, 2);
    clk_ce_cpu = 1'b0; irq_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("gate.hold%0d", c), 32'(irq_req), 0);
    end
    clk_ce_cpu = 1'b1; step();
    check("gate.idle", 32'(irq_req), 0);
    step();
    check_out("gate.rereq", 1, 2, 2);
    $display("gate: ack handshake done, request reasserted req=%0b", irq_req);

    // Reset in the middle of a handshake.
    reset = 1'b1; step(); reset = 1'b0;
    check_out("midreset", 0, 0, 0);
    check("midreset.act", 32'(bus_data_out), 0);
    $display("midreset: req=%0b vector=%0d act=%02h", irq_req, irq_vector, bus_data_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
